// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, opcode/cmd fields, datapath select values and condition codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/multicycle_ctrl_condlogic.sv
// mc_condlogic: {N,Z,C,V} flag register plus ARM condition evaluation.
// CondEx comes from the registered flags only; flag writes are gated by CondEx.
module mc_condlogic
    import multicycle_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_wr,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= RESET_FLAGS;
        end else begin
            if (i_flag_wr[1] && o_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_wr[0] && o_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    // cond 1111 falls into the default and never executes
    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: state FSM, instruction decode, write enables.
// Define CMP_TST_EN to decode CMP as SUB and TST as AND with no register write.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    state_t     r_state, w_next;
    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_cond_ex, w_pcw, w_irw, w_rw, w_mw, w_unused;
    logic [1:0] w_dp_alu, w_flag_wr;
    logic       w_dp_impl, w_dp_nowr, w_dp_cv, w_dp_wr;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_cmd    = w_funct[4:1];
    assign w_rd     = Instr[3:0];
    assign w_unused = ^Instr[7:4];

    always_comb begin
        w_dp_alu  = ALU_ADD;
        w_dp_impl = 1'b0;
        w_dp_nowr = 1'b0;
        w_dp_cv   = 1'b0;
        case (w_cmd)
            CMD_ADD: begin w_dp_alu = ALU_ADD; w_dp_impl = 1'b1; w_dp_cv = 1'b1; end
            CMD_SUB: begin w_dp_alu = ALU_SUB; w_dp_impl = 1'b1; w_dp_cv = 1'b1; end
            CMD_AND: begin w_dp_alu = ALU_AND; w_dp_impl = 1'b1; end
            CMD_ORR: begin w_dp_alu = ALU_ORR; w_dp_impl = 1'b1; end
`ifdef CMP_TST_EN
            CMD_CMP: begin w_dp_alu = ALU_SUB; w_dp_impl = 1'b1; w_dp_nowr = 1'b1; w_dp_cv = 1'b1; end
            CMD_TST: begin w_dp_alu = ALU_AND; w_dp_impl = 1'b1; w_dp_nowr = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_dp_wr = w_dp_impl & ~w_dp_nowr;

    // CMP/TST exist only to set flags, so they write them regardless of S
    always_comb begin
        w_flag_wr = 2'b00;
        if ((r_state == EXECUTER || r_state == EXECUTEI) && w_dp_impl &&
            (w_funct[0] || w_dp_nowr)) begin
            w_flag_wr = {1'b1, w_dp_cv};
        end
    end

    mc_condlogic #(
        .RESET_FLAGS (RESET_FLAGS)
    ) u_condlogic (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_flag_wr   (w_flag_wr),
        .o_cond_ex   (w_cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (w_op)
                    OP_MEM:  w_next = MEMADR;
                    OP_DP:   w_next = w_funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   w_next = BRANCH;
                    default: w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = w_funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = MEMWB;
            EXECUTER: w_next = ALUWB;
            EXECUTEI: w_next = ALUWB;
            default:  w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pcw      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        w_mw       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (r_state)
            FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:  ALUSrcB = SRCB_IMM;
            MEMREAD: AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                w_rw      = w_cond_ex;
                w_pcw     = w_cond_ex && (w_rd == 4'd15);
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                w_mw   = w_cond_ex;
            end
            EXECUTER: ALUControl = w_dp_alu;
            EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_dp_alu;
            end
            ALUWB: begin
                w_rw  = w_cond_ex && w_dp_wr;
                w_pcw = w_cond_ex && w_dp_wr && (w_rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                w_pcw     = w_cond_ex;
            end
            default: ;
        endcase
    end

    // reset holds the FETCH decode visible but must not let it write anything
    assign PCWrite  = w_pcw & ~reset;
    assign IRWrite  = w_irw & ~reset;
    assign RegWrite = w_rw  & ~reset;
    assign MemWrite = w_mw  & ~reset;

    assign ImmSrc = w_op;
    assign RegSrc = {w_op == OP_MEM, w_op == OP_BR};
    assign State  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each issued instruction queues its
// expected per-cycle control vector, popped and compared as the FSM runs.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    localparam logic [3:0] TB_RESET_FLAGS = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;

    multicycle_ctrl #(.RESET_FLAGS(TB_RESET_FLAGS)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    // {state, pcw, irw, rw, mw, adr, srca, srcb, res, aluc}
    logic [15:0] sb[$];
    logic [3:0]  m_flags;
    int          n_total = 0;
    int          n_pass  = 0;

    function automatic logic [15:0] mk(input logic [3:0] st, input logic pcw, irw, rw, mw,
                                       adr, srca, input logic [1:0] srcb, res, aluc);
        return {st, pcw, irw, rw, mw, adr, srca, srcb, res, aluc};
    endfunction

    function automatic logic [15:0] observed();
        return {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;           4'h1: return !z;
            4'h2: return cf;          4'h3: return !cf;
            4'h4: return n;           4'h5: return !n;
            4'h6: return v;           4'h7: return !v;
            4'h8: return cf && !z;    4'h9: return !cf || z;
            4'hA: return n == v;      4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // queue the expected cycles of one instruction and advance the flag model
    task automatic issue(input logic [19:0] ins, input logic [3:0] af);
        logic ce, wr, nz, cv, frc;
        logic [1:0] aluc;
        logic [3:0] rd;
        ce = cond_ok(ins[19:16], m_flags);
        rd = ins[3:0];
        sb.push_back(mk(FETCH,  1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        sb.push_back(mk(DECODE, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        case (ins[15:14])
            2'b01: begin
                sb.push_back(mk(MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
                if (ins[8]) begin
                    sb.push_back(mk(MEMREAD, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
                    sb.push_back(mk(MEMWB, ce && rd == 15, 0, ce, 0, 0, 0, 2'b00, 2'b01, 2'b00));
                end else begin
                    sb.push_back(mk(MEMWRITE, 0, 0, 0, ce, 1, 0, 2'b00, 2'b00, 2'b00));
                end
            end
            2'b00: begin
                aluc = 2'b00; wr = 0; nz = 0; cv = 0; frc = 0;
                case (ins[12:9])
                    4'b0100: begin aluc = 2'b00; wr = 1; nz = 1; cv = 1; end
                    4'b0010: begin aluc = 2'b01; wr = 1; nz = 1; cv = 1; end
                    4'b0000: begin aluc = 2'b10; wr = 1; nz = 1; end
                    4'b1100: begin aluc = 2'b11; wr = 1; nz = 1; end
`ifdef CMP_TST_EN
                    4'b1010: begin aluc = 2'b01; nz = 1; cv = 1; frc = 1; end
                    4'b1000: begin aluc = 2'b10; nz = 1; frc = 1; end
`endif
                    default: ;
                endcase
                sb.push_back(mk(ins[13] ? EXECUTEI : EXECUTER, 0, 0, 0, 0, 0, 0,
                                ins[13] ? 2'b01 : 2'b00, 2'b00, aluc));
                wr = wr && ce;
                sb.push_back(mk(ALUWB, wr && rd == 15, 0, wr, 0, 0, 0, 2'b00, 2'b00, 2'b00));
                if (ce && (ins[8] || frc)) begin
                    if (nz) m_flags[3:2] = af[3:2];
                    if (cv) m_flags[1:0] = af[1:0];
                end
            end
            2'b10: sb.push_back(mk(BRANCH, ce, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00));
            default: ;
        endcase
        Instr    = ins;
        ALUFlags = af;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        e = mk(FETCH, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
        reset = 1'b1; Instr = 20'hE5901; ALUFlags = 4'hF;
        m_flags = TB_RESET_FLAGS;
        @(negedge clk); #1;
        n_total++;
        if (observed() !== e) $display("FAIL reset_hold got=%h expected=%h", observed(), e);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (observed() !== e) $display("FAIL reset_edge got=%h expected=%h", observed(), e);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_data_proc();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        // ADD #5, ORR, ADD into PC, EORS (unimplemented), ADD cond NV, Op=11
        prog = '{24'hE2802_0, 24'hE1804_0, 24'hE280F_0, 24'hE0310_4,
                 24'hF2802_0, 24'hEC000_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL data_proc instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_load_store();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        prog = '{24'hE5901_0, 24'hE590F_0, 24'hE5801_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL load_store instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        // SUBS sets Z, BEQ taken; SUBS clears Z, BEQ not taken despite live ALUFlags Z=1
        prog = '{24'hE0503_6, 24'h0A000_0, 24'hE0503_0, 24'h0A000_4};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL branch instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
        n_total++;
        if ({ImmSrc, RegSrc} !== 4'b1001)
            $display("FAIL branch_srcsel got=%b expected=1001", {ImmSrc, RegSrc});
        else n_pass++;
    endtask

    task automatic test_cond_store();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        prog = '{24'hE0503_4, 24'h15801_0, 24'hE5801_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL cond_store instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_cmp();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        // clear flags, CMP R0,#0 with Z=1 C=1 from the ALU, then BEQ and BCS
        prog = '{24'hE0503_0, 24'hE3500_6, 24'h0A000_0, 24'h2A000_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL cmp instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_partial_flags();
        logic [23:0] prog[$];
        logic [15:0] e, o;
        // ANDS updates only N,Z; EORS updates nothing
        prog = '{24'hE0503_3, 24'hE0105_C, 24'h2A000_0, 24'h4A000_0, 24'h6A000_0,
                 24'h1A000_0, 24'hE0310_0, 24'h0A000_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL partial_flags instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] tbl[$];
        logic [15:0] e, o;
        tbl = '{20'hE2802, 20'hE5901, 20'hE5801, 20'hE0503, 20'h0A000, 20'h1A000,
                20'h2A000, 20'h15801, 20'hE3500, 20'hE0105, 20'hE1804, 20'hEC000,
                20'hE0310, 20'hF2802, 20'hE280F, 20'hE590F, 20'h4A000, 20'hC2802};
        for (int k = 0; k < 40; k++) begin
            issue(tbl[$urandom_range(0, tbl.size() - 1)], 4'($urandom_range(0, 15)));
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL back_to_back instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [23:0] prog[$];
        logic [15:0] e, o, r;
        r = mk(FETCH, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
        issue(20'hE0503, 4'b0110);
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL abort_setup instr=%h got=%h expected=%h", Instr, o, e);
            else n_pass++;
            @(negedge clk);
        end
        issue(20'hE5901, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            e = sb.pop_front(); o = observed(); n_total++;
            if (o !== e) $display("FAIL abort_ldr cycle=%0d got=%h expected=%h", k, o, e);
            else n_pass++;
            if (k < 3) @(negedge clk);
        end
        reset = 1'b1;
        sb.delete();
        m_flags = TB_RESET_FLAGS;
        #1;
        n_total++;
        if (observed() !== r) $display("FAIL abort_async got=%h expected=%h", observed(), r);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (observed() !== r) $display("FAIL abort_hold got=%h expected=%h", observed(), r);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        // Z was 1 before reset; the reset flags make BEQ fall through
        prog = '{24'h0A000_4, 24'hE2802_0};
        foreach (prog[i]) begin
            issue(prog[i][23:4], prog[i][3:0]);
            while (sb.size() > 0) begin
                #1;
                e = sb.pop_front(); o = observed(); n_total++;
                if (o !== e) $display("FAIL abort_after instr=%h got=%h expected=%h", Instr, o, e);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_proc();
        test_load_store();
        test_branch();
        test_cond_store();
        test_cmp();
        test_partial_flags();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RESET_FLAGS, default 4'b0000, meaning value loaded into the {N,Z,C,V} flag register on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Instr  input  20  instruction bits [31:12], read from the instruction register.
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write enables for the PC, instruction register, register file and data memory.
REQ-007 AdrSrc  output  1  memory address select (0 = PC, 1 = ALU result register).
REQ-008 ALUSrcA  output  1; ALUSrcB  output  2  ALU operand selects (A: 0 = register, 1 = PC; B: 00 = register, 01 = immediate, 10 = constant 4).
REQ-009 ResultSrc  output  2  result select (00 = ALUOut, 01 = Data, 10 = ALUResult).
REQ-010 ImmSrc, RegSrc, ALUControl  output  2 each  same encodings as the single-cycle decoder.
REQ-011 State  output  4  current FSM state, for debug.

Function
REQ-012 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-013 FETCH SHALL always go to DECODE.
- FETCH outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1.
REQ-014 DECODE SHALL branch on Op as follows:
- 01 -> MEMADR
- 00 with Funct[5]=0 -> EXECUTER
- 00 with Funct[5]=1 -> EXECUTEI
- 10 -> BRANCH
- 11 -> FETCH, with all write enables at 0
REQ-015 MEMADR SHALL go to MEMREAD when L=1 and to MEMWRITE when L=0.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
REQ-016 Instruction latency SHALL be: LDR 5 cycles, STR 4, data processing 4, B 3, unimplemented 2.
REQ-017 CondEx SHALL be evaluated from the registered flags, never from ALUFlags, using the ARM cond table; cond=1111 SHALL give CondEx=0.
REQ-018 The following SHALL be asserted only when CondEx=1:
- MemWrite, in MEMWRITE.
- RegWrite, in MEMWB and ALUWB.
- PCWrite, in BRANCH.
REQ-019 A write with Rd=15 in MEMWB or ALUWB SHALL assert PCWrite together with RegWrite, and ResultSrc SHALL select the written value.
REQ-020 Flags SHALL update at the end of EXECUTER or EXECUTEI when S=1 and CondEx=1, as follows:
- N and Z for every implemented data-processing op.
- C and V only for ADD, SUB and CMP.
REQ-021 An unimplemented data-processing funct SHALL give ALUControl=00, RegWrite=0 and no flag update, and SHALL still take the 4-cycle path.
REQ-022 Outside the states named above, every write enable SHALL be 0.

Reset
REQ-023 Asserting reset at any time, including mid-instruction, SHALL force the state to FETCH and the flags to RESET_FLAGS, and SHALL abort any pending write.
REQ-024 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0 and the other outputs SHALL show the FETCH decode.
- The first FETCH SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro CMP_TST_EN defined: funct 1010 (CMP) SHALL decode as SUB and funct 1000 (TST) as AND.
- Both take the EXECUTE -> ALUWB path with RegWrite forced to 0 (NoWrite) and flags always written when CondEx=1.
REQ-026 Macro CMP_TST_EN undefined: funct 1010 and 1000 SHALL be treated as unimplemented per REQ-021.

Structure
REQ-027 The shared package multicycle_pkg SHALL hold:
- the state_t enum;
- Op encodings;
- ALUControl, ResultSrc and ALUSrcB constants;
- cond-code constants.
REQ-028 The flag register and condition check SHALL be one sub-module, mc_condlogic, instantiated once; the FSM and decode SHALL stay in multicycle_ctrl.

Verification
REQ-029 Scenario 1, ADD R2,R0,#5 (E2802005): the state sequence SHALL be FETCH, DECODE, EXECUTEI, ALUWB, with RegWrite=1 only in ALUWB.
REQ-030 Scenario 2, LDR R1,[R0,#4] (E5901004): the states SHALL span 5 cycles, with AdrSrc=1 in MEMREAD and ResultSrc=01 with RegWrite=1 in MEMWB.
REQ-031 Scenario 3, SUBS R3,R0,R0 followed by BEQ (0A000002): Z SHALL be 1 after SUBS, and PCWrite SHALL be 1 in BRANCH.
- With Z=0 instead, PCWrite SHALL be 0 in BRANCH.
REQ-032 Scenario 4, STR with cond NE while Z=1: MemWrite SHALL be 0 in MEMWRITE and the FSM SHALL return to FETCH after 4 cycles.
REQ-033 Scenario 5, with CMP_TST_EN, CMP R0,#0 where R0=0: RegWrite SHALL be 0 in ALUWB and the flags SHALL become Z=1, C=1.
REQ-034 Scenario 6, reset pulsed during MEMREAD: the next state SHALL be FETCH, the flags 0000, and RegWrite SHALL never assert for the aborted LDR.
